seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Parametrised bit-serial magnitude comparator. It captures two WIDTH-bit operands on a start strobe and scans them MSB-first, stopping at the first differing bit. It reports the result on the red/green/blue LED outputs with a busy/done handshake. It sits between the switch/operand logic and the board LEDs, and generalises the 2-bit combinational comparator to arbitrary width with registered, held results.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse; result LEDs valid from this cycle.
- greenled  output  1  a > b (registered, held).
- redled  output  1  a < b (registered, held).
- blueled  output  1  a == b (registered, held).

## Operation
- Reset value: state IDLE, busy=0, done=0, greenled=redled=blueled=0, bit index = WIDTH-1.
- IDLE
  - start=1: capture a and b into internal registers, set index to WIDTH-1, go to SCAN.
  - start=0: stay in IDLE.
- SCAN: each cycle, compare captured bit a[idx] against b[idx].
  - If the bits differ: write the result LEDs, pulse done, go to DONE.
  - If the bits are equal and idx=0: set blueled=1 with the other two LEDs 0, pulse done, go to DONE.
  - Otherwise: decrement idx and stay in SCAN.
- DONE: single cycle with done=1 and busy=1; next state is IDLE unconditionally.
- LED update rule
  - Exactly one LED is high after the first completed comparison.
  - All three LEDs are written together, only at the edge that raises done.
  - LEDs are not cleared by start. They hold the previous result until the next done.
- start is ignored while in SCAN or DONE, including the DONE cycle itself. No queuing.
- Changes on a and b after capture have no effect on the running comparison.
- Reset mid-operation: returns to IDLE, clears busy, done and all LEDs, and produces no done pulse.

## Timing
- Capture edge E0: start=1 in IDLE. busy is high from E0.
- Let k be the index of the first differing bit from the MSB.
  - done rises at edge E0 + (WIDTH − k).
  - If a == b, done rises at E0 + WIDTH.
- Latency range: minimum 1 cycle (MSB differs), maximum WIDTH cycles (equal, or only the LSB differs).
- done is high for exactly one cycle. busy falls one edge after done rises.
- The next start is accepted at the earliest on the edge after busy falls. Back-to-back throughput is latency + 2 cycles.
- The LEDs and done change on the same edge.

## Configuration
- CMP_SIGNED_EN defined: operands are two's complement.
  - At idx = WIDTH-1, a differing MSB inverts the decision: a[MSB]=1 with b[MSB]=0 gives redled (a<b); the opposite gives greenled.
  - Lower bits keep the normal ordering.
  - Latency is unchanged.
- CMP_SIGNED_EN undefined: unsigned comparison at all bit positions.

## Test plan
- Reset: hold rst=1 for 2 cycles → busy=0, done=0, all LEDs 0. Release with start=0 → outputs stay 0.
- WIDTH=8, a=0xA5, b=0x25, start pulse → done at E0+1, greenled=1, redled=0, blueled=0; busy low at E0+2.
- a=0x10, b=0x11 → done at E0+8, redled=1. Then a=b=0x3C → done at E0+8, blueled=1. The LEDs hold between the two runs.
- a=0x80, b=0x01
  - without CMP_SIGNED_EN → greenled=1 at E0+1;
  - with CMP_SIGNED_EN → redled=1 at E0+1.
- a=0x02, b=0x01: change a/b and pulse start again at E0+3 while in SCAN → second start ignored, one done at E0+7 with greenled=1.
- Start a=0x00, b=0x01, assert rst at E0+4 → no done pulse, LEDs=0, busy=0. Then a new start (a=0xFF, b=0xFE) completes normally with greenled=1 at E0+8.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
// Bit-serial MSB-first magnitude comparator with a busy/done handshake.
// Operands are captured on an accepted start. The scan stops at the first
// differing bit. The verdict is written to the green/red/blue LEDs, which
// hold their value until the next done pulse.
// Optional build macro: CMP_SIGNED_EN selects two's-complement operands.
// When it is undefined, the comparison is unsigned.
module seq_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greenled,
  output logic             redled,
  output logic             blueled
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [WIDTH-1:0] diff_bits;
  logic             bit_diff;
  logic             a_bit;
  logic             b_bit;
  logic             a_gt_next;

  // Per-bit inequality of the captured operands.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = a_reg[gi] ^ b_reg[gi];
    end
  endgenerate

  // Select the bit under scan and decide the ordering if it differs.
  always_comb begin
    bit_diff  = diff_bits[idx_reg];
    a_bit     = a_reg[idx_reg];
    b_bit     = b_reg[idx_reg];
    a_gt_next = a_bit;
`ifdef CMP_SIGNED_EN
    // The sign bit carries negative weight, so its ordering is reversed.
    if (idx_reg == IDX_MSB) begin
      a_gt_next = b_bit;
    end
`endif
  end

  // Control FSM with registered handshake and LED outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= IDX_MSB;
      busy      <= 1'b0;
      done      <= 1'b0;
      greenled  <= 1'b0;
      redled    <= 1'b0;
      blueled   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            idx_reg   <= IDX_MSB;
            busy      <= 1'b1;
            state_reg <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bit_diff) begin
            greenled  <= a_gt_next;
            redled    <= ~a_gt_next;
            blueled   <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else if (idx_reg == '0) begin
            greenled  <= 1'b0;
            redled    <= 1'b0;
            blueled   <= 1'b1;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        ST_DONE: begin
          // Start is ignored here as well; there is no request queuing.
          done      <= 1'b0;
          busy      <= 1'b0;
          idx_reg   <= IDX_MSB;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed testbench for seq_magnitude_comparator (WIDTH=8).
// The expected LED patterns {green,red,blue} and latencies are hand-computed.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             greenled;
  logic             redled;
  logic             blueled;

  int compared_cnt;
  int mismatch_cnt;

  seq_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .greenled (greenled),
    .redled   (redled),
    .blueled  (blueled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] leds();
    return {29'd0, greenled, redled, blueled};
  endfunction

  // Runs one comparison and checks capture, latency, result, and busy release.
  task automatic do_cmp(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input int exp_lat, input logic [2:0] exp_leds,
                        input logic [2:0] prev_leds);
    int lat;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_done_e0"}, done, 0);
    check({tag, "_hold_e0"}, leds(), prev_leds);
    lat = 0;
    for (int n = 1; n <= WIDTH + 2 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_leds"}, leds(), exp_leds);
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_done_fall"}, done, 0);
    $display("txn %s a=%02h b=%02h latency=%0d leds(g,r,b)=%03b", tag, aa, bb, lat, leds());
  endtask

  initial begin
    int first_done;
    int done_cnt;
    logic [2:0] msb_exp;
    compared_cnt = 0;
    mismatch_cnt = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_leds", leds(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_leds", leds(), 0);
    $display("txn reset busy=%0b done=%0b leds=%03b", busy, done, leds());

    // MSB differs, then LSB differs, then equal; LEDs hold between runs
    do_cmp("a5_25", 8'hA5, 8'h25, 1, 3'b100, 3'b000);
    do_cmp("10_11", 8'h10, 8'h11, 8, 3'b010, 3'b100);
    do_cmp("3c_3c", 8'h3C, 8'h3C, 8, 3'b001, 3'b010);

`ifdef CMP_SIGNED_EN
    msb_exp = 3'b010;
`else
    msb_exp = 3'b100;
`endif
    do_cmp("80_01", 8'h80, 8'h01, 1, msb_exp, 3'b001);

    // A second start during SCAN is ignored
    @(negedge clk);
    a = 8'h02; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_done = 0;
    done_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) begin
        start = 1'b1; a = 8'h01; b = 8'h02;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
    end
    check("ign_done_cnt", done_cnt, 1);
    check("ign_latency", first_done, 7);
    check("ign_leds", leds(), 3'b100);
    check("ign_busy", busy, 0);
    $display("txn ignore_start a=02 b=01 latency=%0d dones=%0d leds=%03b", first_done, done_cnt, leds());

    // Reset mid-scan aborts without a done pulse
    @(negedge clk);
    a = 8'h00; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 4) rst = 1'b1;
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_done_cnt", done_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_leds", leds(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_after_done", done, 0);
    $display("txn reset_abort busy=%0b leds=%03b", busy, leds());
    do_cmp("ff_fe", 8'hFF, 8'hFE, 8, 3'b100, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule
